// File: rtl/fetch_pc_stage.sv
// Fetch front-end: owns the PC, drives the next-PC mux select, issues synchronous
// instruction-memory reads and buffers returned words in a 2-entry queue for decode.
module fetch_pc_stage #(
    parameter int unsigned     PC_W     = 6,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               trap,
    output logic [1:0]         pc_sel,
    output logic [PC_W-1:0]    pc_plus1,
    input  logic [PC_W-1:0]    next_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [PC_W-1:0]    dec_pc,
    output logic [INSTR_W-1:0] dec_instr
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic [PC_W-1:0]    q_pc    [2];
    logic [INSTR_W-1:0] q_instr [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;
    logic               redirect, deq, enq, fire;
    logic [2:0]         credit;

    always_comb begin
        pc_sel = 2'b00;
        if (trap)
            pc_sel = 2'b11;
        else if (jump)
            pc_sel = 2'b10;
        else if (branch_taken)
            pc_sel = 2'b01;
    end

    assign redirect  = trap | jump | branch_taken;
    assign pc_plus1  = pc + PC_W'(1);
    assign imem_addr = pc;

    assign dec_valid = (count != 2'd0);
    assign dec_pc    = q_pc[rd_ptr];
    assign dec_instr = q_instr[rd_ptr];

    assign deq = dec_valid & dec_ready;
    assign enq = inflight & ~redirect;
    // Credit counts queued words plus the word still in flight, so a fetch is only
    // issued when its response is guaranteed a free slot.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN:  fire    = ~redirect & (credit < 3'd2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc       <= RESET_PC;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc       <= next_pc;
                inflight <= 1'b0;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (fire)
                    pc <= next_pc;
                inflight <= fire;
                if (enq)
                    wr_ptr <= ~wr_ptr;
                if (deq)
                    rd_ptr <= ~rd_ptr;
                if (enq && !deq)
                    count <= count + 2'd1;
                else if (!enq && deq)
                    count <= count - 2'd1;
            end
        end
    end

    // Payload registers need no reset; validity is carried by inflight and count.
    always_ff @(posedge clk) begin
        if (fire)
            inflight_pc <= pc;
        if (enq) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
